// File: rtl/adder_pkg.sv
// Shared definitions for the adder/subtractor family: FSM state encoding
// and the digit-counter width helper.
package adder_pkg;

  // Three-state handshake FSM used by the serial datapaths.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width for n/d digits; never narrower than one bit so that
  // the single-digit configuration still has a legal counter.
  function automatic int cnt_width(input int n, input int d);
    int w;
    w = $clog2(n / d);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/ripple_borrow_slice.sv
// D-bit ripple-borrow subtract slice: d = x - y - bi, bo = borrow out.
module ripple_borrow_slice #(
  parameter int D = 4
) (
  input  logic [D-1:0] x,
  input  logic [D-1:0] y,
  input  logic         bi,
  output logic [D-1:0] d,
  output logic         bo
);

  logic [D:0] br_s;

  assign br_s[0] = bi;

  for (genvar i = 0; i < D; i++) begin : g_bit
    assign d[i]      = x[i] ^ y[i] ^ br_s[i];
    assign br_s[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br_s[i]);
  end

  assign bo = br_s[D];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: computes a - b - bin over N/D cycles, one
// D-bit digit per cycle, with the borrow carried between digits in a
// register. Valid/ready handshakes on both operand and result sides.
module serial_subtractor
  import adder_pkg::*;
#(
  parameter int N = 32,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic [N:0]   final_diff,
  output logic         ovf
);

  localparam int NDIG = N / D;
  localparam int CW   = cnt_width(N, D);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIG - 1);

  state_t        state_r;
  state_t        state_next_s;
  logic          accept_s;
  logic          last_s;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [CW-1:0] cnt_r;
  logic [N-1:0]  a_sh_r;
  logic [N-1:0]  b_sh_r;
  logic          borrow_r;
  logic          a_msb_r;
  logic          b_msb_r;
  logic [N-1:0]  diff_r;
  logic          bout_r;
  logic          ovf_r;
  logic [D-1:0]  d_s;
  logic          bo_s;

  // Low digit of the shifted operands goes through the single slice.
  ripple_borrow_slice #(.D(D)) u_slice (
    .x  (a_sh_r[D-1:0]),
    .y  (b_sh_r[D-1:0]),
    .bi (borrow_r),
    .d  (d_s),
    .bo (bo_s)
  );

  // Next-state logic plus accept / last-digit strobes.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          accept_s     = 1'b1;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == LAST_DIGIT) begin
          last_s       = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered handshake flags derived from next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == ST_IDLE);
      out_valid_r <= (state_next_s == ST_DONE);
    end
  end

  // Operand capture, digit-serial shift/borrow update and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r    <= {CW{1'b0}};
      a_sh_r   <= {N{1'b0}};
      b_sh_r   <= {N{1'b0}};
      borrow_r <= 1'b0;
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      diff_r   <= {N{1'b0}};
      bout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (accept_s) begin
      cnt_r    <= {CW{1'b0}};
      a_sh_r   <= a;
      b_sh_r   <= b;
      borrow_r <= bin;
      a_msb_r  <= a[N-1];
      b_msb_r  <= b[N-1];
    end else if (state_r == ST_RUN) begin
      cnt_r                      <= cnt_r + CW'(1);
      a_sh_r                     <= a_sh_r >> D;
      b_sh_r                     <= b_sh_r >> D;
      borrow_r                   <= bo_s;
      diff_r[int'(cnt_r) * D +: D] <= d_s;
      if (last_s) begin
        // Top digit's MSB is the result sign used for overflow.
        bout_r <= bo_s;
        ovf_r  <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ d_s[D-1]);
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign diff       = diff_r;
  assign bout       = bout_r;
  assign ovf        = ovf_r;
  assign final_diff = {bout_r, diff_r};

endmodule
